// File: rtl/truth_table_sweep.sv
// truth_table_sweep: drives {a,b,c,d} through all 16 input combinations of a
// 4-input combinational block, samples its output f_in once per vector after a
// settle delay, assembles the measured truth table and compares it against
// EXPECTED. Results (table_out, err_count, pass) hold until the next accepted
// start or reset.
module truth_table_sweep #(
  parameter logic [15:0] EXPECTED = 16'h0000,
  parameter int unsigned SETTLE   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        f_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] table_out,
  output logic [4:0]  err_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // The settle counter counts down from SETTLE-1 to 0, so APPLY lasts
  // exactly SETTLE cycles before the single SAMPLE cycle.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  idx;
  logic [3:0]  settle_cnt;
  logic        mismatch;
  logic        last_vec;
  logic [4:0]  err_nxt;

  // Adds one mismatch to the running count; 16 vectors fit in 5 bits, so no
  // saturation is needed.
  function automatic logic [4:0] bump_err(input logic [4:0] cnt, input logic miss);
    return cnt + {4'd0, miss};
  endfunction

  // Stimulus and status are decoded straight from registered state.
  assign {a, b, c, d} = idx;
  assign busy         = (state == APPLY) || (state == SAMPLE);
  assign done         = (state == DONE);

  assign mismatch = (f_in != EXPECTED[idx]);
  assign last_vec = (idx == 4'hF);
  assign err_nxt  = bump_err(err_count, mismatch);

  // Next-state decode for the sweep sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = APPLY;
      APPLY:   if (settle_cnt == 4'd0) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = last_vec ? DONE : APPLY;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset aborts any sweep in progress.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Vector index and settle counter: index advances after each sample and
  // returns to 0 after the last vector so the stimulus idles at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= 4'd0;
      settle_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx        <= 4'd0;
            settle_cnt <= SETTLE_LOAD;
          end
        end
        APPLY: begin
          if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
        end
        SAMPLE: begin
          if (last_vec) begin
            idx <= 4'd0;
          end else begin
            idx        <= idx + 4'd1;
            settle_cnt <= SETTLE_LOAD;
          end
        end
        default: begin
          idx <= 4'd0;
        end
      endcase
    end
  end

  // Result capture: results clear on an accepted start, accumulate during
  // SAMPLE, and pass is decided on the last vector including its own mismatch.
  always_ff @(posedge clk) begin
    if (rst) begin
      table_out <= 16'h0000;
      err_count <= 5'd0;
      pass      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            table_out <= 16'h0000;
            err_count <= 5'd0;
            pass      <= 1'b0;
          end
        end
        SAMPLE: begin
          table_out[idx] <= f_in;
          err_count      <= err_nxt;
          if (last_vec) pass <= (err_nxt == 5'd0);
        end
        default: begin
          table_out <= table_out;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweep.sv
// Bench for truth_table_sweep: five instances share clk/rst/start, each wired
// to its own model of the block under test:
//   0: EXPECTED=0000, SETTLE=1, f_in = f_mode (constant 0 or 1)
//   1: EXPECTED=F000, SETTLE=1, f_in = a&b
//   2: EXPECTED=F001, SETTLE=1, f_in = a&b
//   3: EXPECTED=55AA, SETTLE=3, f_in = a^d delayed by two registers
//   4: EXPECTED=55AA, SETTLE=1, f_in = a^d delayed by two registers
// With SETTLE=1 the two-register delay makes index i capture f(i-1) (i>=1),
// giving measured table AB54 and 14 mismatches against 55AA.
module tb_truth_table_sweep;

  localparam int N = 5;

  logic        clk;
  logic        rst;
  logic        start;
  logic        f_mode;
  logic        f_in      [N];
  logic        a         [N];
  logic        b         [N];
  logic        c         [N];
  logic        d         [N];
  logic        busy      [N];
  logic        done      [N];
  logic        pass      [N];
  logic [15:0] tbl       [N];
  logic [4:0]  errc      [N];

  int checks;
  int failures;
  int edges;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar k = 0; k < N; k++) begin : g_dut
    truth_table_sweep #(
      .EXPECTED(k == 0 ? 16'h0000 : k == 1 ? 16'hF000 : k == 2 ? 16'hF001 : 16'h55AA),
      .SETTLE  (k == 3 ? 3 : 1)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .f_in     (f_in[k]),
      .a        (a[k]),
      .b        (b[k]),
      .c        (c[k]),
      .d        (d[k]),
      .busy     (busy[k]),
      .done     (done[k]),
      .pass     (pass[k]),
      .table_out(tbl[k]),
      .err_count(errc[k])
    );

    if (k == 0) begin : g_const
      assign f_in[k] = f_mode;
    end else if (k <= 2) begin : g_and
      assign f_in[k] = a[k] & b[k];
    end else begin : g_xor_dly
      logic dly1;
      logic dly2;
      always @(posedge clk) begin
        dly1 <= a[k] ^ d[k];
        dly2 <= dly1;
      end
      assign f_in[k] = dly2;
    end
  end

  function automatic logic [3:0] abcd(input int k);
    return {a[k], b[k], c[k], d[k]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    edges++;
  endtask

  // Edge 0 (the one sampling start) is the reference; returns at the negedge
  // after it with edges=0.
  task automatic launch(input bit hold);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    edges = 0;
  endtask

  task automatic wait_done(input int k, input int exp_edges, input string tag);
    while (done[k] !== 1'b1 && edges < exp_edges + 40) step();
    check_eq(tag, edges, exp_edges);
  endtask

  task automatic check_result(input int k, input logic [15:0] t, input logic [4:0] e,
                              input logic p, input string tag);
    check_eq({tag, "_table"}, tbl[k], t);
    check_eq({tag, "_err"}, errc[k], e);
    check_eq({tag, "_pass"}, pass[k], p);
  endtask

  initial begin
    int bad;
    checks   = 0;
    failures = 0;
    edges    = 0;
    rst      = 1'b1;
    start    = 1'b0;
    f_mode   = 1'b0;
    repeat (3) @(negedge clk);

    check_eq("rst_busy", busy[1], 1'b0);
    check_eq("rst_done", done[1], 1'b0);
    check_eq("rst_abcd", abcd(1), 4'h0);
    check_result(1, 16'h0000, 5'd0, 1'b0, "rst");

    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Sweep 1: f=0 on k0, a&b on k1/k2, delayed a^d on k3/k4
    launch(1'b0);
    bad = 0;
    if (abcd(0) !== 4'h0 || busy[0] !== 1'b1) bad++;
    for (int n = 1; n <= 31; n++) begin
      step();
      if (abcd(0) !== 4'(n / 2) || busy[0] !== 1'b1 || pass[0] !== 1'b0) bad++;
    end
    check_eq("walk_idx", bad, 0);
    wait_done(0, 32, "s1_done_edges");
    check_eq("s1_done_k4", done[4], 1'b1);
    check_result(0, 16'h0000, 5'd0, 1'b1, "s1_zero");
    check_result(1, 16'hF000, 5'd0, 1'b1, "s1_and");
    check_result(2, 16'hF000, 5'd1, 1'b0, "s1_and_f001");
    check_result(4, 16'hAB54, 5'd14, 1'b0, "s1_xor_fast");
    step();
    check_eq("s1_done_pulse", done[0], 1'b0);
    check_eq("s1_idle_busy", busy[1], 1'b0);
    check_eq("s1_idle_abcd", abcd(1), 4'h0);
    wait_done(3, 64, "s3_done_edges");
    check_result(3, 16'h55AA, 5'd0, 1'b1, "s3_xor_slow");
    repeat (3) step();

    // Sweep 2: f=1 constant on k0
    f_mode = 1'b1;
    launch(1'b0);
    repeat (10) step();
    check_eq("pass_mid_sweep", pass[1], 1'b0);
    wait_done(0, 32, "ones_done_edges");
    check_result(0, 16'hFFFF, 5'd16, 1'b0, "ones");
    wait_done(3, 64, "s3b_done_edges");
    repeat (3) step();

    // start ignored mid-sweep and in DONE
    launch(1'b0);
    while (edges < 10) step();
    check_eq("ign_idx5", abcd(1), 4'h5);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(1, 32, "ign_done_edges");
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("ign_done_start", busy[1], 1'b0);
    step();
    check_eq("ign_still_idle", busy[1], 1'b0);
    check_result(1, 16'hF000, 5'd0, 1'b1, "ign");
    wait_done(3, 64, "ign_s3_edges");
    repeat (3) step();

    // start held high: back-to-back sweeps with one IDLE cycle
    launch(1'b1);
    wait_done(1, 32, "hold_done1");
    step();
    check_eq("hold_gap_busy", busy[1], 1'b0);
    step();
    check_eq("hold_restart", busy[1], 1'b1);
    wait_done(1, 66, "hold_done2");
    start = 1'b0;
    check_result(1, 16'hF000, 5'd0, 1'b1, "hold");
    repeat (3) step();

    // reset mid-sweep at idx=7
    f_mode = 1'b1;
    launch(1'b0);
    while (edges < 14) step();
    check_eq("mid_idx7", abcd(1), 4'h7);
    check_eq("mid_table", tbl[0], 16'h007F);
    check_eq("mid_err", errc[0], 5'd7);
    rst = 1'b1;
    step();
    check_eq("abort_busy", busy[1], 1'b0);
    check_eq("abort_abcd", abcd(1), 4'h0);
    check_eq("abort_done", done[1], 1'b0);
    check_result(0, 16'h0000, 5'd0, 1'b0, "abort_k0");
    check_eq("abort_pass_k1", pass[1], 1'b0);
    rst    = 1'b0;
    f_mode = 1'b0;
    repeat (3) step();

    launch(1'b0);
    wait_done(1, 32, "post_done_edges");
    check_result(1, 16'hF000, 5'd0, 1'b1, "post");
    check_result(0, 16'h0000, 5'd0, 1'b1, "post_k0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
